// File: rtl/mov_sched.sv
// Round-robin scheduler that shares one fixed-latency move pipeline among four cores.
// A valid/id tag travels alongside each operand so the result is returned to its owner.
module mov_sched #(
  parameter int unsigned DW  = 64,
  parameter int unsigned LAT = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] req_data,
  output logic [3:0]      gnt,
  output logic [3:0]      busy,
  output logic [DW-1:0]   pipe_in,
  input  logic [DW-1:0]   pipe_out,
  output logic            resp_valid,
  output logic [1:0]      resp_id,
  output logic [DW-1:0]   resp_data
);

  localparam int unsigned NC = 4;
  localparam int unsigned IW = 2;

  logic [IW-1:0]  r_ptr;
  logic [NC-1:0]  r_gnt;
  logic [NC-1:0]  r_busy;
  logic [DW-1:0]  r_pipe_in;
  logic [LAT-1:0] r_tag_vld;
  logic [IW-1:0]  r_tag_id [LAT];
  logic           r_resp_valid;
  logic [IW-1:0]  r_resp_id;

  logic [NC-1:0]  w_elig;
  logic           w_found;
  logic [IW-1:0]  w_win;
  logic [IW-1:0]  w_idx;
  logic [NC-1:0]  w_busy_nxt;

  // Round-robin search starting one past the last winner.
  always_comb begin
    w_elig  = req & ~r_busy;
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NC; k++) begin
      w_idx = r_ptr + IW'(k);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // A core's busy bit clears as its result leaves; a new grant sets it.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_resp_valid) begin
      w_busy_nxt[r_resp_id] = 1'b0;
    end
    if (w_found) begin
      w_busy_nxt[w_win] = 1'b1;
    end
  end

  // The tag enters stage 0 with the operand at pipe_in; the response register
  // adds the final edge so the tag lines up with pipe_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr        <= 2'd3;
      r_gnt        <= '0;
      r_busy       <= '0;
      r_pipe_in    <= '0;
      r_tag_vld    <= '0;
      for (int unsigned s = 0; s < LAT; s++) begin
        r_tag_id[s] <= '0;
      end
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
    end else begin
      r_busy       <= w_busy_nxt;
      r_tag_vld    <= {r_tag_vld[LAT-2:0], w_found};
      r_tag_id[0]  <= w_found ? w_win : '0;
      for (int unsigned s = 1; s < LAT; s++) begin
        r_tag_id[s] <= r_tag_id[s-1];
      end
      r_resp_valid <= r_tag_vld[LAT-1];
      r_resp_id    <= r_tag_id[LAT-1];
      r_gnt        <= '0;
      if (w_found) begin
        r_gnt     <= NC'(1) << w_win;
        r_pipe_in <= req_data[32'(w_win)*DW +: DW];
        r_ptr     <= w_win;
      end
    end
  end

  assign gnt        = r_gnt;
  assign busy       = r_busy;
  assign pipe_in    = r_pipe_in;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_data  = pipe_out;

endmodule
